// File: rtl/crc16_frame_checker.sv
// -----------------------------------------------------------------------------
// crc16_frame_checker
//   Receives a byte stream framed by sof/eof and checks its trailing CRC-16.
//   Each frame carries payload + CRC high byte + CRC low byte. A good frame
//   therefore leaves the running CRC register at zero.
//
//   The CRC update is MSB-first, non-reflected, uses POLY and has no final
//   XOR. It processes one whole byte per clock.
//
//   Results are published in the single CHECK cycle that follows the eof byte.
//   frame_done pulses in that cycle, and the result flags hold until the next
//   frame_done.
//
// Ports
//   clk, rst_n     : clock (rising edge), async active-low reset
//   data[7:0]      : received byte, bit 7 first
//   data_valid     : data/sof/eof are valid
//   sof / eof      : first / last byte of a frame
//   data_ready     : byte accepted when data_valid & data_ready
//   frame_done     : one-cycle pulse, frame result published
//   crc_ok/crc_err : last frame passed / failed
//   len_err        : last frame shorter than 3 bytes or overran MAX_LEN
//   residue[15:0]  : final CRC register of last frame
//   byte_cnt[15:0] : bytes accepted in current or last frame
//   err_cnt[7:0]   : failed-frame count, saturating at 255
// -----------------------------------------------------------------------------
module crc16_frame_checker #(
    parameter logic [15:0] POLY    = 16'h1021,
    parameter logic [15:0] INIT    = 16'h0000,
    parameter int unsigned MAX_LEN = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data,
    input  logic        data_valid,
    input  logic        sof,
    input  logic        eof,
    output logic        data_ready,
    output logic        frame_done,
    output logic        crc_ok,
    output logic        crc_err,
    output logic        len_err,
    output logic [15:0] residue,
    output logic [15:0] byte_cnt,
    output logic [7:0]  err_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RECV  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    // Eight unrolled shift/XOR steps, i.e. one byte per clock.
    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = (r << 1) ^ POLY;
            else              r = r << 1;
        end
        return r;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [15:0] crc_q, crc_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ovr_d;
    logic        accept;
    logic        len_d, ok_d;
    logic        crc_ok_q, crc_err_q, len_err_q;
    logic [15:0] residue_q;
    logic [7:0]  err_cnt_q;

    assign data_ready = (state_q != S_CHECK);
    assign frame_done = (state_q == S_CHECK);
    assign accept     = data_valid & data_ready;

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        ovr_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Bytes without sof are dropped silently.
                if (accept && sof) begin
                    crc_d   = crc_upd(INIT, data);
                    cnt_d   = 16'd1;
                    state_d = eof ? S_CHECK : S_RECV;
                end
            end
            S_RECV: begin
                if (accept) begin
                    if (sof) begin
                        // A new sof abandons the partial frame and restarts.
                        crc_d   = crc_upd(INIT, data);
                        cnt_d   = 16'd1;
                        state_d = eof ? S_CHECK : S_RECV;
                    end else begin
                        crc_d = crc_upd(crc_q, data);
                        cnt_d = cnt_q + 16'd1;
                        if (eof) begin
                            state_d = S_CHECK;
                        end else if (cnt_d == MAX_LEN_W) begin
                            state_d = S_CHECK;
                            ovr_d   = 1'b1;
                        end
                    end
                end
            end
            S_CHECK: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Results are captured on the edge that enters CHECK.
    // They are therefore already visible while frame_done is high.
    assign len_d = (cnt_d < 16'd3) | ovr_d;
    assign ok_d  = (crc_d == 16'h0000) & ~len_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            crc_q     <= INIT;
            cnt_q     <= 16'd0;
            residue_q <= 16'd0;
            crc_ok_q  <= 1'b0;
            crc_err_q <= 1'b0;
            len_err_q <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            if (state_d == S_CHECK) begin
                residue_q <= crc_d;
                len_err_q <= len_d;
                crc_ok_q  <= ok_d;
                crc_err_q <= ~ok_d;
                if (!ok_d && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign crc_ok   = crc_ok_q;
    assign crc_err  = crc_err_q;
    assign len_err  = len_err_q;
    assign residue  = residue_q;
    assign byte_cnt = cnt_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: doc/crc16_frame_checker.md
CRC16_FRAME_CHECKER -- requirements
Module: crc16_frame_checker

Interface
REQ-001 The block SHALL have parameter POLY, default 16'h1021, meaning the CRC-16 generator polynomial with the x^16 term implied.
REQ-002 The block SHALL have parameter INIT, default 16'h0000, meaning the CRC register value at frame start.
REQ-003 The block SHALL have parameter MAX_LEN, default 4096, meaning the maximum accepted frame length in bytes, including the 2 CRC bytes.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port data, input, 8 bits: received byte, with data[7] processed first.
REQ-007 The block SHALL have port data_valid, input, 1 bit: data, sof and eof are valid.
REQ-008 The block SHALL have port sof, input, 1 bit: the current byte is the first byte of a frame.
REQ-009 The block SHALL have port eof, input, 1 bit: the current byte is the last byte of a frame (CRC low byte).
REQ-010 The block SHALL have port data_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-011 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when the frame result is published.
REQ-012 The block SHALL have port crc_ok, output, 1 bit: the last frame passed.
REQ-013 The block SHALL have port crc_err, output, 1 bit: the last frame failed.
REQ-014 The block SHALL have port len_err, output, 1 bit: the last frame was shorter than 3 bytes or reached MAX_LEN without eof.
REQ-015 The block SHALL have port residue, output, 16 bits: final CRC register value of the last frame.
REQ-016 The block SHALL have port byte_cnt, output, 16 bits: bytes accepted in the current or last frame.
REQ-017 The block SHALL have port err_cnt, output, 8 bits: failed-frame counter, saturating.

Function
REQ-018 A byte SHALL be accepted only in a cycle where data_valid=1 and data_ready=1.
REQ-019 On each accepted byte, the CRC register SHALL be updated byte-parallel, in one cycle, with the MSB-first, non-reflected update using POLY, with no final XOR.
REQ-020 Frame encoding SHALL be: payload followed by the CRC high byte then the CRC low byte, so that a good frame leaves residue 16'h0000.
REQ-021 The state machine SHALL have states IDLE, RECV and CHECK.
REQ-022 data_ready SHALL be 1 in IDLE and RECV and 0 in CHECK.
REQ-023 In IDLE, an accepted byte with sof=1 SHALL set crc = update(INIT, data) and byte_cnt=1, then go to RECV; if eof=1 in the same cycle it SHALL go to CHECK instead.
REQ-024 In IDLE, an accepted byte with sof=0 SHALL be discarded, with no change to any output.
REQ-025 In RECV, an accepted byte SHALL update crc and increment byte_cnt.
REQ-026 In RECV, an accepted byte with eof=1 SHALL cause a transition to CHECK.
REQ-027 In RECV, an accepted byte with sof=1 SHALL restart the frame exactly as in REQ-023; the partial frame is dropped, with no frame_done and no err_cnt change.
REQ-028 In RECV, if byte_cnt reaches MAX_LEN without eof, the block SHALL go to CHECK with an overrun flag set; sof has priority over eof, and eof has priority over overrun.
REQ-029 CHECK SHALL last exactly 1 cycle and then return to IDLE; frame_done=1 only in that cycle.
REQ-030 In the CHECK cycle, the results SHALL be registered as follows:
- residue = crc
- len_err = (byte_cnt<3) | overrun
- crc_ok = (crc==0) & ~len_err
- crc_err = ~crc_ok
REQ-031 crc_ok, crc_err, len_err and residue SHALL hold their values until the next frame_done.
REQ-032 err_cnt SHALL increment on each frame_done with crc_err=1, saturating at 255.
REQ-033 Latency SHALL be: frame_done asserts on the cycle after the eof byte is accepted.
REQ-034 data_valid gaps of any length SHALL be allowed in IDLE and RECV, with no effect on state.
REQ-035 Bytes presented while in CHECK are not accepted; the sender SHALL hold them.

Reset
REQ-036 While rst_n=0, the block SHALL asynchronously force:
- state to IDLE
- crc to INIT
- byte_cnt, residue and err_cnt to 0
- crc_ok, crc_err, len_err and frame_done to 0
- data_ready to 1
REQ-037 Reset mid-frame SHALL discard the partial frame, produce no frame_done, and make the next sof start a clean frame.

Verification
REQ-038 The bench SHALL cover a good frame: send "123456789" (0x31..0x39) then 0x31, 0xC3 with eof on the last byte -> frame_done 1 cycle after eof, crc_ok=1, residue=0x0000, byte_cnt=11, err_cnt=0.
REQ-039 The bench SHALL cover a corrupted frame: the same frame with the first byte set to 0x30 -> crc_err=1, crc_ok=0, residue!=0, err_cnt=1.
REQ-040 The bench SHALL cover a short frame: sof=1 on byte 0xAA, then eof=1 on byte 0x55 -> len_err=1, crc_err=1, byte_cnt=2.
REQ-041 The bench SHALL cover back-pressure and gaps: the good frame with random data_valid gaps, and the next sof presented in the CHECK cycle -> data_ready=0 for 1 cycle, the held byte is accepted the next cycle, and both frames pass.
REQ-042 The bench SHALL cover reset and restart: rst_n pulsed low after 4 bytes, or sof re-asserted mid-frame, followed by the good frame -> exactly one frame_done, with crc_ok=1.
REQ-043 The bench SHALL cover saturation and overrun:
- 256 corrupted frames -> err_cnt=255 and held there
- with MAX_LEN=16, 16 bytes without eof -> len_err=1 and frame_done asserted
